// File: rtl/btn_conditioner.sv
// Two-channel pushbutton conditioner: synchronizes the raw buttons, debounces
// each channel with its own qualification FSM, emits one-cycle press strobes
// and keeps the run/pause level that start/pause toggles.
//
//   state        | meaning
//   -------------+--------------------------------------------------
//   IDLE         | button released and accepted as released
//   PRESS_WAIT   | high seen, counting stable-high cycles
//   PRESSED      | press accepted, waiting for release
//   RELEASE_WAIT | low seen, counting stable-low cycles
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic [1:0] btn,
    output logic [1:0] btn_db,
    output logic       clr_pulse,
    output logic       start_pulse,
    output logic       run
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    // Terminal count of the stability counter; the counter never passes it.
    localparam logic [26:0] CNT_LAST = 27'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_a;
    logic [1:0]       sync_q;
    logic [1:0][1:0]  state_q;
    logic [1:0][1:0]  state_nx;
    logic [1:0][26:0] cnt_q;
    logic [1:0][26:0] cnt_nx;
    logic [1:0]       accept;

    // Two-flop synchronizer per button; only sync_q feeds the FSMs.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            sync_a <= btn;
            sync_q <= sync_a;
        end
    end

    // Per-channel qualification FSM next-state and counter logic.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nx[i] = state_q[i];
            cnt_nx[i]   = cnt_q[i];
            accept[i]   = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (sync_q[i]) begin
                        state_nx[i] = PRESS_WAIT;
                        cnt_nx[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_q[i]) begin
                        state_nx[i] = IDLE;
                        cnt_nx[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_nx[i] = PRESSED;
                        cnt_nx[i]   = '0;
                        accept[i]   = 1'b1;
                    end else begin
                        cnt_nx[i] = cnt_q[i] + 27'd1;
                    end
                end
                PRESSED: begin
                    // Holding the button does nothing further: no auto-repeat.
                    if (!sync_q[i]) begin
                        state_nx[i] = RELEASE_WAIT;
                        cnt_nx[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_q[i]) begin
                        state_nx[i] = PRESSED;
                        cnt_nx[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_nx[i] = IDLE;
                        cnt_nx[i]   = '0;
                    end else begin
                        cnt_nx[i] = cnt_q[i] + 27'd1;
                    end
                end
                default: begin
                    state_nx[i] = IDLE;
                    cnt_nx[i]   = '0;
                end
            endcase
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= {IDLE, IDLE};
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
        end
    end

    // Strobes fire the cycle after acceptance; run flips on that same edge.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            clr_pulse   <= 1'b0;
            start_pulse <= 1'b0;
            run         <= 1'b1;
        end else begin
            clr_pulse   <= accept[0];
            start_pulse <= accept[1];
            run         <= run ^ accept[1];
        end
    end

    // Debounced level is high from acceptance until the release is qualified.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            btn_db[i] = (state_q[i] == PRESSED) || (state_q[i] == RELEASE_WAIT);
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

    logic       mclk;
    logic       rst_n;
    logic [1:0] btn;
    logic [1:0] btn_db;
    logic       clr_pulse;
    logic       start_pulse;
    logic       run;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [1:0] btn;
        logic [1:0] db;
        logic       clr;
        logic       start;
        logic       run;
    } vec_t;

    vec_t vec [20];

    btn_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .btn         (btn),
        .btn_db      (btn_db),
        .clr_pulse   (clr_pulse),
        .start_pulse (start_pulse),
        .run         (run)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive btn, then sample outputs 1 time unit after the next rising edge.
    task automatic step(input logic [1:0] b);
        btn = b;
        @(posedge mclk);
        #1;
    endtask

    task automatic check_outs(input string name, input logic [1:0] db,
                              input logic clr, input logic start, input logic r);
        check({name, ".btn_db"}, {30'd0, btn_db}, {30'd0, db});
        check({name, ".clr_pulse"}, {31'd0, clr_pulse}, {31'd0, clr});
        check({name, ".start_pulse"}, {31'd0, start_pulse}, {31'd0, start});
        check({name, ".run"}, {31'd0, run}, {31'd0, r});
    endtask

    task automatic do_reset();
        btn   = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        check_outs("reset", 2'b00, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        int n_clr;
        int n_start;
        n_cmp  = 0;
        n_fail = 0;
        btn    = 2'b00;
        rst_n  = 1'b1;
        #2;
        rst_n  = 1'b0;

        // Clean press of start/pause sampled at edge 0, released at edge 10.
        vec[0]  = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b1};
        vec[1]  = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b1};
        vec[2]  = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b1};
        vec[3]  = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b1};
        vec[4]  = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b1};
        vec[5]  = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b1};
        vec[6]  = '{2'b10, 2'b10, 1'b0, 1'b1, 1'b0};
        vec[7]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
        vec[8]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
        vec[10] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
        vec[11] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
        vec[12] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
        vec[13] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
        vec[14] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
        vec[15] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
        vec[16] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vec[17] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vec[18] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vec[19] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(vec[i].btn);
            check_outs($sformatf("clean[%0d]", i), vec[i].db, vec[i].clr, vec[i].start, vec[i].run);
        end

        // Press bounce on clear: 1,1,0,0,1,1,0,0 then held; final rise sampled at edge 8.
        do_reset();
        n_clr = 0;
        for (int i = 0; i < 30; i++) begin
            step((i < 8 && ((i / 2) % 2 == 1)) ? 2'b00 : 2'b01);
            n_clr += int'(clr_pulse);
            if (i == 13) check_outs("bounce.e13", 2'b00, 1'b0, 1'b0, 1'b1);
            if (i == 14) check_outs("bounce.e14", 2'b01, 1'b1, 1'b0, 1'b1);
        end
        check("bounce.count", n_clr, 1);
        check("bounce.run", {31'd0, run}, 1);

        // Release bounce: low at 10-11, glitch high at 12-13, stable low from 14.
        do_reset();
        n_clr = 0;
        for (int i = 0; i < 30; i++) begin
            step((i < 10 || i == 12 || i == 13) ? 2'b01 : 2'b00);
            n_clr += int'(clr_pulse);
            if (i == 15) check("relbounce.db15", {30'd0, btn_db}, 2'b01);
            if (i == 19) check("relbounce.db19", {30'd0, btn_db}, 2'b01);
            if (i == 20) check("relbounce.db20", {30'd0, btn_db}, 2'b00);
        end
        check("relbounce.count", n_clr, 1);

        // Simultaneous press on both channels.
        do_reset();
        n_clr = 0;
        n_start = 0;
        for (int i = 0; i < 20; i++) begin
            step(2'b11);
            n_clr += int'(clr_pulse);
            n_start += int'(start_pulse);
            if (i == 5) check_outs("simul.e5", 2'b00, 1'b0, 1'b0, 1'b1);
            if (i == 6) check_outs("simul.e6", 2'b11, 1'b1, 1'b1, 1'b0);
        end
        check("simul.clr_count", n_clr, 1);
        check("simul.start_count", n_start, 1);
        check("simul.run_end", {31'd0, run}, 0);

        // Reset mid-press: channel 1 in PRESS_WAIT with cnt=2, channel 0 held.
        do_reset();
        for (int i = 0; i < 25; i++) begin
            step((i < 10 || i >= 20) ? 2'b11 : 2'b01);
            if (i == 16) check("rstmid.db16", {30'd0, btn_db}, 2'b01);
        end
        check_outs("rstmid.before", 2'b01, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("rstmid.async", 2'b00, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge mclk);
        #1;
        check_outs("rstmid.held", 2'b00, 1'b0, 1'b0, 1'b1);
        @(negedge mclk);
        rst_n = 1'b1;
        n_start = 0;
        for (int r = 0; r < 10; r++) begin
            step(2'b11);
            n_start += int'(start_pulse);
            if (r < 6)
                check_outs($sformatf("rstmid.r%0d", r), 2'b00, 1'b0, 1'b0, 1'b1);
            else if (r == 6)
                check_outs("rstmid.r6", 2'b11, 1'b1, 1'b1, 1'b0);
        end
        check("rstmid.count", n_start, 1);

        // Long hold then a second press: run goes 1 -> 0 -> 1.
        do_reset();
        n_start = 0;
        for (int i = 0; i < 1000; i++) begin
            step(2'b10);
            n_start += int'(start_pulse);
        end
        check("long.count", n_start, 1);
        check("long.run1", {31'd0, run}, 0);
        check("long.db", {30'd0, btn_db}, 2'b10);
        for (int i = 0; i < 20; i++) step(2'b00);
        check("long.db_rel", {30'd0, btn_db}, 2'b00);
        n_start = 0;
        for (int i = 0; i < 20; i++) begin
            step(2'b10);
            n_start += int'(start_pulse);
        end
        check("long.count2", n_start, 1);
        check("long.run2", {31'd0, run}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
